// File: rtl/alu_pkg.sv
// Shared EX-stage ALU definitions: add/sub opcode encoding and the flag bundle.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cb;    // carry-out (ADD) / borrow-out (SUB)
        logic ovf;   // two's-complement signed overflow
        logic zero;  // result == 0
        logic neg;   // result MSB
    } addsub_flags_t;

endpackage

// File: rtl/addsub_segment.sv
// One SEG-bit slice of the segmented carry chain (purely combinational).
// Ports:
//   a, b   operand slice; b is already inverted for subtraction
//   cin    carry into the slice
//   sum    slice sum, cout carry out of the slice
//   ovf    signed-overflow term, valid only when this is the top slice
//   zero   slice sum is all zeros
module addsub_segment #(
    parameter int unsigned SEG = 32
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           ovf,
    output logic           zero
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + (SEG + 1)'(cin);

    // Same-sign operands producing an opposite-sign result
    assign ovf  = (a[SEG-1] == b[SEG-1]) && (sum[SEG-1] != a[SEG-1]);
    assign zero = (sum == '0);

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES segments,
// one resolved per cycle, with valid/ready flow control and result flags.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              operation handshake (in_op, in_a, in_b, in_cb)
//   out_valid/out_ready            result handshake
//   out_result                     A+B+cb or A-B-cb modulo 2^WIDTH
//   out_cb, out_ovf, out_zero, out_neg   carry/borrow, overflow, zero, negative
module pipelined_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cb,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int unsigned SEG = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > 8) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $fatal(1, "pipelined_addsub: STAGES must be 1..8 and divide WIDTH");
    end

    // Whole pipeline moves together; a stalled result freezes every stage
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    addsub_flags_t flags_q;
    addsub_flags_t flags_nxt;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned REM = WIDTH - k * SEG;  // operand bits not yet summed

        logic [REM-1:0]         a_in;
        logic [REM-1:0]         b_in;
        logic                   cin;
        logic                   op_in;
        logic                   v_in;
        logic                   z_in;
        logic [SEG-1:0]         sum;
        logic                   cout;
        logic                   seg_ovf;
        logic                   seg_zero;
        logic [(k+1)*SEG-1:0]   res_nxt;
        logic [(k+1)*SEG-1:0]   res;
        logic                   vld;

        // Stage inputs: raw operands for stage 0, skewed registers afterwards
        if (k == 0) begin : g_src
            assign a_in    = in_a;
            assign b_in    = (in_op == OP_ADD) ? in_b : ~in_b;
            assign cin     = in_op ^ in_cb;  // SUB: A + ~B + ~borrow
            assign op_in   = in_op;
            assign v_in    = in_valid;
            assign z_in    = 1'b1;
            assign res_nxt = sum;
        end else begin : g_src
            assign a_in    = g_stage[k-1].g_fwd.a_hi;
            assign b_in    = g_stage[k-1].g_fwd.b_hi;
            assign cin     = g_stage[k-1].g_fwd.carry;
            assign op_in   = g_stage[k-1].g_fwd.op;
            assign v_in    = g_stage[k-1].vld;
            assign z_in    = g_stage[k-1].g_fwd.zacc;
            assign res_nxt = {sum, g_stage[k-1].res};
        end

        addsub_segment #(.SEG(SEG)) u_seg (
            .a    (a_in[SEG-1:0]),
            .b    (b_in[SEG-1:0]),
            .cin  (cin),
            .sum  (sum),
            .cout (cout),
            .ovf  (seg_ovf),
            .zero (seg_zero)
        );

        // Valid bit and accumulated low-order result
        always_ff @(posedge clk) begin
            if (rst) begin
                vld <= 1'b0;
                res <= '0;
            end else if (advance) begin
                vld <= v_in;
                res <= res_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-SEG-1:0] a_hi;
            logic [REM-SEG-1:0] b_hi;
            logic               carry;
            logic               op;
            logic               zacc;
            logic               unused_ovf;

            // Overflow is only meaningful on the top slice
            assign unused_ovf = seg_ovf;

            // Delay the untouched upper operand bits and chain state
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_hi  <= '0;
                    b_hi  <= '0;
                    carry <= 1'b0;
                    op    <= 1'b0;
                    zacc  <= 1'b0;
                end else if (advance) begin
                    a_hi  <= a_in[REM-1:SEG];
                    b_hi  <= b_in[REM-1:SEG];
                    carry <= cout;
                    op    <= op_in;
                    zacc  <= z_in & seg_zero;
                end
            end
        end else begin : g_last
            assign flags_nxt.cb   = op_in ^ cout;  // SUB reports borrow = ~carry
            assign flags_nxt.ovf  = seg_ovf;
            assign flags_nxt.zero = z_in & seg_zero;
            assign flags_nxt.neg  = sum[SEG-1];
            assign out_valid      = vld;
            assign out_result     = res;
        end
    end

    // Flags register alongside the final result slice
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (advance) begin
            flags_q <= flags_nxt;
        end
    end

    assign out_cb   = flags_q.cb;
    assign out_ovf  = flags_q.ovf;
    assign out_zero = flags_q.zero;
    assign out_neg  = flags_q.neg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: one flow-controlled STAGES=2 unit plus
// STAGES=1,4,8 units fed the same accepted operations.
module tb_pipelined_addsub;
    import alu_pkg::*;

    localparam int NI = 4;
    localparam int W  = 64;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;   // {cb, ovf, zero, neg}
        int           acc;
        bit           lat;
    } exp_t;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cb;
        logic [W-1:0] r;
        logic [3:0]   f;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid;
    logic         in_op;
    logic         in_cb;
    logic         out_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;

    logic         in_ready_a  [NI];
    logic         out_valid_a [NI];
    logic         out_cb_a    [NI];
    logic         out_ovf_a   [NI];
    logic         out_zero_a  [NI];
    logic         out_neg_a   [NI];
    logic [W-1:0] out_result_a[NI];

    int   stg_a[NI] = '{2, 1, 4, 8};
    exp_t q[NI][$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < NI; i++) begin : g_dut
        localparam int unsigned S = (i == 0) ? 2 : (i == 1) ? 1 : (i == 2) ? 4 : 8;
        logic vin;
        logic ordy;
        if (i == 0) begin : g_main
            assign vin  = in_valid;
            assign ordy = out_ready;
        end else begin : g_aux
            assign vin  = in_valid && in_ready_a[0];
            assign ordy = 1'b1;
        end
        pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (vin),
            .in_ready   (in_ready_a[i]),
            .in_op      (in_op),
            .in_a       (in_a),
            .in_b       (in_b),
            .in_cb      (in_cb),
            .out_valid  (out_valid_a[i]),
            .out_ready  (ordy),
            .out_result (out_result_a[i]),
            .out_cb     (out_cb_a[i]),
            .out_ovf    (out_ovf_a[i]),
            .out_zero   (out_zero_a[i]),
            .out_neg    (out_neg_a[i])
        );
    end

    task automatic chk(input string name, input int inst, input logic [W-1:0] act,
                       input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s inst%0d (STAGES=%0d): got %h, expected %h",
                     name, inst, stg_a[inst], act, expv);
        end
    endtask

    // Independent reference: full-width arithmetic with an extra bit
    function automatic logic [W+3:0] model(input logic op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic cb);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         v;
        if (op == OP_SUB) begin
            s = {1'b0, a} - {1'b0, b} - (W + 1)'(cb);
            v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            s = {1'b0, a} + {1'b0, b} + (W + 1)'(cb);
            v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
        r = s[W-1:0];
        return {r, s[W], v, (r == '0), r[W-1]};
    endfunction

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < NI; i++) if (q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    // Pops and compares every presented result; checks holding during stalls
    task automatic monitor();
        logic [W-1:0] p_res[NI];
        logic [3:0]   p_flg[NI];
        bit           stl[NI];
        exp_t         e;
        logic [3:0]   f;
        bit           rdy;
        for (int i = 0; i < NI; i++) stl[i] = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < NI; i++) stl[i] = 1'b0;
                continue;
            end
            for (int i = 0; i < NI; i++) begin
                f   = {out_cb_a[i], out_ovf_a[i], out_zero_a[i], out_neg_a[i]};
                rdy = (i == 0) ? out_ready : 1'b1;
                if (stl[i]) begin
                    chk("stall_valid",  i, W'(out_valid_a[i]), W'(1));
                    chk("stall_result", i, out_result_a[i], p_res[i]);
                    chk("stall_flags",  i, W'(f), W'(p_flg[i]));
                end
                if (out_valid_a[i]) begin
                    if (rdy) begin
                        if (q[i].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL spurious inst%0d: out_valid=1 result=%h, expected no result",
                                     i, out_result_a[i]);
                        end else begin
                            e = q[i].pop_front();
                            chk("result", i, out_result_a[i], e.res);
                            chk("flags",  i, W'(f), W'(e.flg));
                            if (e.lat) chk("latency", i, W'(cyc - e.acc), W'(stg_a[i]));
                        end
                    end else begin
                        chk("stall_in_ready", i, W'(in_ready_a[i]), W'(0));
                        p_res[i] = out_result_a[i];
                        p_flg[i] = f;
                    end
                end
                stl[i] = out_valid_a[i] && !rdy;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the op is accepted
    task automatic send(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cb, input logic [W-1:0] xr, input logic [3:0] xf,
                        input bit lat);
        exp_t e;
        bit   done = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_cb    = cb;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready_a[0]) begin
                e = '{res: xr, flg: xf, acc: cyc, lat: lat};
                for (int i = 0; i < NI; i++) q[i].push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=0 for 200 cycles, expected accept");
        end
    endtask

    task automatic send_m(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cb, input bit lat);
        logic [W+3:0] m;
        m = model(op, a, b, cb);
        send(op, a, b, cb, m[W+3:4], m[3:0], lat);
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && !all_empty(); t++) @(negedge clk);
        if (!all_empty()) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q[0].size());
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{OP_SUB, 64'h64, 64'h32, 1'b0, 64'h32, 4'b0000};
        vecs[1]  = '{OP_SUB, 64'hFFFF_FFFF_FFFF_FFCE, 64'h19, 1'b0, 64'hFFFF_FFFF_FFFF_FFB5, 4'b0001};
        vecs[2]  = '{OP_SUB, 64'h19, 64'h32, 1'b1, 64'hFFFF_FFFF_FFFF_FFE6, 4'b1001};
        vecs[3]  = '{OP_SUB, 64'h5, 64'h5, 1'b0, 64'h0, 4'b0010};
        vecs[4]  = '{OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 4'b0101};
        vecs[5]  = '{OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 4'b1010};
        vecs[6]  = '{OP_ADD, 64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 64'h0000_0001_0000_0000, 4'b0000};
        vecs[7]  = '{OP_SUB, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0100};
        vecs[8]  = '{OP_SUB, 64'h0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1001};
        vecs[9]  = '{OP_ADD, 64'h0000_0001_0000_0000, 64'h0, 1'b0, 64'h0000_0001_0000_0000, 4'b0000};
        vecs[10] = '{OP_ADD, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 64'h0, 4'b1010};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = OP_ADD;
        in_a      = '0;
        in_b      = '0;
        in_cb     = 1'b0;
        out_ready = 1'b1;

        fork
            monitor();
        join_none
        fork
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation did not complete, expected completion");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_out_valid", i, W'(out_valid_a[i]), W'(0));
            chk("rst_in_ready",  i, W'(in_ready_a[i]), W'(1));
            chk("rst_result",    i, out_result_a[i], W'(0));
            chk("rst_flags",     i, W'({out_cb_a[i], out_ovf_a[i], out_zero_a[i], out_neg_a[i]}), W'(0));
        end
        @(posedge clk);
        #1;

        // Directed vectors one at a time, exact latency checked
        for (int v = 0; v < 11; v++) begin
            send(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].cb, vecs[v].r, vecs[v].f, 1'b1);
            drain();
        end

        // Back-to-back issue without stall: full throughput at exact latency
        for (int v = 0; v < 6; v++)
            send(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].cb, vecs[v].r, vecs[v].f, 1'b1);
        drain();

        // Stream of 8 with out_ready low for 3 cycles mid-stream
        fork
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = 64'h0123_4567_89AB_CDEF * W'(i + 1);
            b = {a[31:0], a[63:32]} ^ W'(i * 7);
            send_m(i[0], a, b, i[1], 1'b0);
        end
        drain();

        // Reset with operations in flight
        send_m(OP_ADD, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, 1'b0);
        send_m(OP_SUB, 64'hDEAD_BEEF_0000_0001, 64'h1, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NI; i++) q[i].delete();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("flush_out_valid", i, W'(out_valid_a[i]), W'(0));
            chk("flush_result",    i, out_result_a[i], W'(0));
        end
        repeat (12) @(posedge clk);
        #1;

        // Recovery after the flush
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].cb, vecs[v].r, vecs[v].f, 1'b1);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
